// File: rtl/axi_slave_mem.sv
// AXI3/AXI4 slave memory: independent write and read FSMs over one word-addressed array.
// Latency: B one cycle after the last W beat; first R beat one cycle after the AR handshake.
// Backpressure: one burst per direction; B/R outputs held stable while the master stalls.
module axi_slave_mem #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  // write address channel
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  // write data channel
  input  logic [ID_WIDTH-1:0]     wid,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  // write response channel
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  // read address channel
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  output logic                    arready,
  // read data channel
  output logic [ID_WIDTH-1:0]     rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int STRB_W    = DATA_WIDTH / 8;
  localparam int BYTE_BITS = $clog2(STRB_W);
  localparam int IDX_W     = $clog2(MEM_DEPTH);
  localparam int MEM_BYTES = MEM_DEPTH * STRB_W;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  // Next beat address for FIXED / INCR / WRAP; WRAP keeps the low bits inside the wrap window.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [7:0]            len,
    input logic [2:0]            size,
    input logic [1:0]            burst
  );
    logic [ADDR_WIDTH-1:0] nbytes;
    logic [ADDR_WIDTH-1:0] aligned;
    logic [ADDR_WIDTH-1:0] wrap_mask;
    nbytes    = ADDR_WIDTH'(1) << size;
    aligned   = addr & ~(nbytes - ADDR_WIDTH'(1));
    wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    case (burst)
      2'b00:   next_addr = addr;
      2'b10:   next_addr = (aligned & ~wrap_mask) | ((aligned + nbytes) & wrap_mask);
      default: next_addr = aligned + nbytes;
    endcase
  endfunction

  // Whole-burst error: reserved burst type, illegal WRAP length, or transfer wider than the bus.
  function automatic logic burst_err(
    input logic [7:0] len,
    input logic [2:0] size,
    input logic [1:0] burst
  );
    logic bad_wrap;
    bad_wrap  = (burst == 2'b10) &&
                (len != 8'd1) && (len != 8'd3) && (len != 8'd7) && (len != 8'd15);
    burst_err = (burst == 2'b11) || bad_wrap || (size > 3'(BYTE_BITS));
  endfunction

  // Beat falls outside the memory's byte range.
  function automatic logic addr_oob(input logic [ADDR_WIDTH-1:0] addr);
    addr_oob = ({1'b0, addr} >= (ADDR_WIDTH+1)'(MEM_BYTES));
  endfunction

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // write-side state
  w_state_t              w_state_q, w_state_d;
  logic [ID_WIDTH-1:0]   awid_q, awid_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [7:0]            awlen_q, awlen_d;
  logic [2:0]            awsize_q, awsize_d;
  logic [1:0]            awburst_q, awburst_d;
  logic [7:0]            wcnt_q, wcnt_d;
  logic                  werr_q, werr_d;
  logic                  wberr_q, wberr_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [ID_WIDTH-1:0]   bid_q, bid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  werr_nxt;
  logic                  mem_we;
  logic                  w_beat_oob;
  logic [IDX_W-1:0]      w_idx;

  // read-side state
  r_state_t              r_state_q, r_state_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [7:0]            arlen_q, arlen_d;
  logic [2:0]            arsize_q, arsize_d;
  logic [1:0]            arburst_q, arburst_d;
  logic [7:0]            rcnt_q, rcnt_d;
  logic                  rberr_q, rberr_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  rlast_q, rlast_d;
  logic [ADDR_WIDTH-1:0] r_next;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_oob;
  logic                  rd_berr;
  logic [IDX_W-1:0]      rd_idx;
  logic [DATA_WIDTH-1:0] rd_word;

  // The write data ID is carried by the protocol but never needed here.
  logic unused_ok;
  assign unused_ok = ^wid;

  assign w_beat_oob = addr_oob(waddr_q);
  assign w_idx      = waddr_q[BYTE_BITS +: IDX_W];

  // Read port address: the incoming AR address when idle, otherwise the following beat.
  assign r_next  = next_addr(raddr_q, arlen_q, arsize_q, arburst_q);
  assign rd_addr = (r_state_q == R_IDLE) ? araddr : r_next;
  assign rd_berr = (r_state_q == R_IDLE) ? burst_err(arlen, arsize, arburst) : rberr_q;
  assign rd_oob  = addr_oob(rd_addr);
  assign rd_idx  = rd_addr[BYTE_BITS +: IDX_W];
  assign rd_word = mem[rd_idx];

  // Write FSM next-state and output decode.
  always_comb begin
    w_state_d = w_state_q;
    awid_d    = awid_q;
    waddr_d   = waddr_q;
    awlen_d   = awlen_q;
    awsize_d  = awsize_q;
    awburst_d = awburst_q;
    wcnt_d    = wcnt_q;
    werr_d    = werr_q;
    wberr_d   = wberr_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    werr_nxt  = werr_q;
    mem_we    = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (awvalid && awready_q) begin
          awid_d    = awid;
          waddr_d   = awaddr;
          awlen_d   = awlen;
          awsize_d  = awsize;
          awburst_d = awburst;
          wcnt_d    = 8'd0;
          wberr_d   = burst_err(awlen, awsize, awburst);
          werr_d    = burst_err(awlen, awsize, awburst);
          awready_d = 1'b0;
          wready_d  = 1'b1;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (wvalid && wready_q) begin
          mem_we   = !wberr_q && !w_beat_oob;
          werr_nxt = werr_q | w_beat_oob | (wlast != (wcnt_q == awlen_q));
          werr_d   = werr_nxt;
          if (wcnt_q == awlen_q) begin
            wready_d  = 1'b0;
            bvalid_d  = 1'b1;
            bid_d     = awid_q;
            bresp_d   = werr_nxt ? RESP_SLVERR : RESP_OKAY;
            w_state_d = W_RESP;
          end else begin
            wcnt_d  = wcnt_q + 8'd1;
            waddr_d = next_addr(waddr_q, awlen_q, awsize_q, awburst_q);
          end
        end
      end
      W_RESP: begin
        if (bvalid_q && bready) begin
          bvalid_d  = 1'b0;
          bid_d     = '0;
          bresp_d   = RESP_OKAY;
          awready_d = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read FSM next-state and output decode; the next word is fetched on the same edge as each handshake.
  always_comb begin
    r_state_d = r_state_q;
    rid_d     = rid_q;
    raddr_d   = raddr_q;
    arlen_d   = arlen_q;
    arsize_d  = arsize_q;
    arburst_d = arburst_q;
    rcnt_d    = rcnt_q;
    rberr_d   = rberr_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (arvalid && arready_q) begin
          rid_d     = arid;
          raddr_d   = araddr;
          arlen_d   = arlen;
          arsize_d  = arsize;
          arburst_d = arburst;
          rcnt_d    = 8'd0;
          rberr_d   = rd_berr;
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rlast_d   = (arlen == 8'd0);
          rresp_d   = (rd_berr || rd_oob) ? RESP_SLVERR : RESP_OKAY;
          rdata_d   = (rd_berr || rd_oob) ? '0 : rd_word;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (rvalid_q && rready) begin
          if (rlast_q) begin
            rvalid_d  = 1'b0;
            rid_d     = '0;
            rdata_d   = '0;
            rresp_d   = RESP_OKAY;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
            r_state_d = R_IDLE;
          end else begin
            raddr_d = r_next;
            rcnt_d  = rcnt_q + 8'd1;
            rlast_d = ((rcnt_q + 8'd1) == arlen_q);
            rresp_d = (rberr_q || rd_oob) ? RESP_SLVERR : RESP_OKAY;
            rdata_d = (rberr_q || rd_oob) ? '0 : rd_word;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Register both FSMs and all handshake/response outputs.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state_q <= W_IDLE;
      awid_q    <= '0;
      waddr_q   <= '0;
      awlen_q   <= '0;
      awsize_q  <= '0;
      awburst_q <= '0;
      wcnt_q    <= '0;
      werr_q    <= 1'b0;
      wberr_q   <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= '0;
      r_state_q <= R_IDLE;
      rid_q     <= '0;
      raddr_q   <= '0;
      arlen_q   <= '0;
      arsize_q  <= '0;
      arburst_q <= '0;
      rcnt_q    <= '0;
      rberr_q   <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      rlast_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      awid_q    <= awid_d;
      waddr_q   <= waddr_d;
      awlen_q   <= awlen_d;
      awsize_q  <= awsize_d;
      awburst_q <= awburst_d;
      wcnt_q    <= wcnt_d;
      werr_q    <= werr_d;
      wberr_q   <= wberr_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
      r_state_q <= r_state_d;
      rid_q     <= rid_d;
      raddr_q   <= raddr_d;
      arlen_q   <= arlen_d;
      arsize_q  <= arsize_d;
      arburst_q <= arburst_d;
      rcnt_q    <= rcnt_d;
      rberr_q   <= rberr_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
    end
  end

  // Byte-lane writes; storage is never reset so contents survive aresetn.
  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wstrb[i]) mem[w_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bid     = bid_q;
  assign bresp   = bresp_q;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rid     = rid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign rlast   = rlast_q;

endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed bench for axi_slave_mem: writes/reads with hand-computed expectations.
// Inputs driven 1 time unit after each rising edge; outputs sampled at the same point.
// Covers INCR/WRAP/FIXED, strobes, error responses, R/B backpressure and mid-burst reset.
module tb_axi_slave_mem;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int DEPTH = 1024;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [IW-1:0] awid, wid, bid, arid, rid;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0]    awlen, arlen;
  logic [2:0]    awsize, arsize;
  logic [1:0]    awburst, arburst, bresp, rresp;
  logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rlast, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [DW/8-1:0] wstrb;

  axi_slave_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MEM_DEPTH(DEPTH)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  logic [DW-1:0]   wbuf [16];
  logic [DW/8-1:0] sbuf [16];
  logic [DW-1:0]   rbuf [16];
  logic [1:0]      rrbuf[16];
  logic            rlbuf[16];
  logic [IW-1:0]   rid_got;
  logic [1:0]      b_resp_got;
  logic [IW-1:0]   b_id_got;
  int              t_bdelay = 0;
  int              t_wlast_at = -1;
  int              t_abort_at = -1;
  bit              t_rrand = 1'b0;

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic do_write(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    bit hs;
    int n;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    hs = 1'b0; n = 0;
    while (!hs && n < 100) begin hs = awready; tick; n++; end
    awvalid = 1'b0;
    if (!hs) check("aw_timeout", 64'(hs), 64'd1);
    for (int i = 0; i <= int'(len); i++) begin
      if (t_abort_at >= 0 && i == t_abort_at) begin
        wvalid = 1'b0;
        return;
      end
      wid = id; wdata = wbuf[i]; wstrb = sbuf[i];
      wlast = (t_wlast_at >= 0) ? (i == t_wlast_at) : (i == int'(len));
      wvalid = 1'b1;
      hs = 1'b0; n = 0;
      while (!hs && n < 100) begin hs = wready; tick; n++; end
      if (!hs) check("w_timeout", 64'(hs), 64'd1);
    end
    wvalid = 1'b0; wlast = 1'b0;
    for (int k = 0; k < t_bdelay; k++) begin
      check("b_hold_vld", 64'(bvalid), 64'd1);
      check("b_hold_id", 64'(bid), 64'(id));
      check("b_hold_awrdy", 64'(awready), 64'd0);
      tick;
    end
    bready = 1'b1;
    hs = 1'b0; n = 0;
    while (!hs && n < 100) begin
      if (bvalid) begin b_resp_got = bresp; b_id_got = bid; end
      hs = bvalid; tick; n++;
    end
    bready = 1'b0;
    if (!hs) check("b_timeout", 64'(hs), 64'd1);
  endtask

  task automatic do_read(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    bit hs;
    int n, nb;
    logic [DW-1:0] sd;
    logic sl;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    hs = 1'b0; n = 0;
    while (!hs && n < 100) begin hs = arready; tick; n++; end
    arvalid = 1'b0;
    if (!hs) check("ar_timeout", 64'(hs), 64'd1);
    check("r_latency", 64'(rvalid), 64'd1);
    nb = 0; n = 0;
    while (nb <= int'(len) && n < 300) begin
      rready = t_rrand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rvalid && rready) begin
        rbuf[nb] = rdata; rrbuf[nb] = rresp; rlbuf[nb] = rlast; rid_got = rid;
        nb++;
        tick;
      end else if (rvalid) begin
        sd = rdata; sl = rlast;
        tick;
        check("stall_vld", 64'(rvalid), 64'd1);
        check("stall_data", 64'(rdata), 64'(sd));
        check("stall_last", 64'(rlast), 64'(sl));
      end else begin
        tick;
      end
      n++;
    end
    rready = 1'b0;
    check("r_beats", 64'(nb), 64'(int'(len) + 1));
    check("r_done", 64'(rvalid), 64'd0);
  endtask

  initial begin
    aresetn = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
    for (int i = 0; i < 16; i++) begin wbuf[i] = '0; sbuf[i] = 4'hF; end

    // reset state
    repeat (3) tick;
    check("rst_awready", 64'(awready), 64'd0);
    check("rst_arready", 64'(arready), 64'd0);
    check("rst_bvalid", 64'(bvalid), 64'd0);
    check("rst_rvalid", 64'(rvalid), 64'd0);
    aresetn = 1'b1;
    tick;
    check("rel_awready", 64'(awready), 64'd1);
    check("rel_arready", 64'(arready), 64'd1);

    // single INCR write/read
    wbuf[0] = 32'hDEADBEEF; sbuf[0] = 4'hF;
    do_write(4'd5, 32'h10, 8'd0, 3'd2, 2'b01);
    check("t1_bresp", 64'(b_resp_got), 64'd0);
    check("t1_bid", 64'(b_id_got), 64'd5);
    do_read(4'd3, 32'h10, 8'd0, 3'd2, 2'b01);
    check("t1_rdata", 64'(rbuf[0]), 64'hDEADBEEF);
    check("t1_rresp", 64'(rrbuf[0]), 64'd0);
    check("t1_rlast", 64'(rlbuf[0]), 64'd1);
    check("t1_rid", 64'(rid_got), 64'd3);

    // INCR write then WRAP read
    for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
    do_write(4'd1, 32'h100, 8'd3, 3'd2, 2'b01);
    check("t2_bresp", 64'(b_resp_got), 64'd0);
    do_read(4'd2, 32'h108, 8'd3, 3'd2, 2'b10);
    check("t2_b0", 64'(rbuf[0]), 64'd3);
    check("t2_b1", 64'(rbuf[1]), 64'd4);
    check("t2_b2", 64'(rbuf[2]), 64'd1);
    check("t2_b3", 64'(rbuf[3]), 64'd2);
    for (int i = 0; i < 4; i++) check("t2_rlast", 64'(rlbuf[i]), 64'(i == 3));

    // partial strobe
    wbuf[0] = 32'h11223344; sbuf[0] = 4'hF;
    do_write(4'd1, 32'h20, 8'd0, 3'd2, 2'b01);
    wbuf[0] = 32'hAABBCCDD; sbuf[0] = 4'b0101;
    do_write(4'd1, 32'h20, 8'd0, 3'd2, 2'b01);
    sbuf[0] = 4'hF;
    do_read(4'd1, 32'h20, 8'd0, 3'd2, 2'b01);
    check("t3_strobe", 64'(rbuf[0]), 64'h11BB33DD);

    // FIXED burst: all beats hit one word
    for (int i = 0; i < 3; i++) wbuf[i] = 32'(7 + i);
    do_write(4'd2, 32'h40, 8'd2, 3'd2, 2'b00);
    do_read(4'd2, 32'h40, 8'd1, 3'd2, 2'b00);
    check("t4_fixed0", 64'(rbuf[0]), 64'd9);
    check("t4_fixed1", 64'(rbuf[1]), 64'd9);

    // out-of-range write leaves word 0 (same low index bits) untouched
    wbuf[0] = 32'hCAFEF00D;
    do_write(4'd1, 32'h0, 8'd0, 3'd2, 2'b01);
    wbuf[0] = 32'h12345678;
    do_write(4'd6, 32'(DEPTH * 4), 8'd0, 3'd2, 2'b01);
    check("t5_oob_bresp", 64'(b_resp_got), 64'd2);
    do_read(4'd1, 32'h0, 8'd0, 3'd2, 2'b01);
    check("t5_mem_keep", 64'(rbuf[0]), 64'hCAFEF00D);
    do_read(4'd1, 32'(DEPTH * 4), 8'd0, 3'd2, 2'b01);
    check("t5_oob_rresp", 64'(rrbuf[0]), 64'd2);
    check("t5_oob_rdata", 64'(rbuf[0]), 64'd0);

    // reserved burst type on read
    do_read(4'd4, 32'h100, 8'd1, 3'd2, 2'b11);
    for (int i = 0; i < 2; i++) begin
      check("t6_rresp", 64'(rrbuf[i]), 64'd2);
      check("t6_rdata", 64'(rbuf[i]), 64'd0);
    end

    // oversize transfer and early wlast
    do_write(4'd1, 32'h60, 8'd0, 3'd3, 2'b01);
    check("t7_size_bresp", 64'(b_resp_got), 64'd2);
    t_wlast_at = 1;
    do_write(4'd7, 32'h300, 8'd3, 3'd2, 2'b01);
    t_wlast_at = -1;
    check("t7_wlast_bresp", 64'(b_resp_got), 64'd2);
    check("t7_wlast_bid", 64'(b_id_got), 64'd7);

    // B backpressure, then R backpressure with random rready
    for (int i = 0; i < 8; i++) wbuf[i] = 32'h1000 + 32'(i);
    t_bdelay = 5;
    do_write(4'd8, 32'h400, 8'd7, 3'd2, 2'b01);
    t_bdelay = 0;
    check("t8_bresp", 64'(b_resp_got), 64'd0);
    t_rrand = 1'b1;
    do_read(4'd9, 32'h400, 8'd7, 3'd2, 2'b01);
    t_rrand = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("t8_rdata", 64'(rbuf[i]), 64'h1000 + 64'(i));
      check("t8_rlast", 64'(rlbuf[i]), 64'(i == 7));
    end
    check("t8_rid", 64'(rid_got), 64'd9);

    // reset in the middle of a len=7 write after 4 beats
    for (int i = 0; i < 8; i++) wbuf[i] = 32'hA0 + 32'(i);
    do_write(4'd1, 32'h200, 8'd7, 3'd2, 2'b01);
    for (int i = 0; i < 8; i++) wbuf[i] = 32'hB0 + 32'(i);
    t_abort_at = 4;
    do_write(4'd2, 32'h200, 8'd7, 3'd2, 2'b01);
    t_abort_at = -1;
    aresetn = 1'b0;
    #1;
    check("t9_awready", 64'(awready), 64'd0);
    check("t9_wready", 64'(wready), 64'd0);
    check("t9_arready", 64'(arready), 64'd0);
    check("t9_bvalid", 64'(bvalid), 64'd0);
    check("t9_rvalid", 64'(rvalid), 64'd0);
    check("t9_rdata", 64'(rdata), 64'd0);
    repeat (2) tick;
    aresetn = 1'b1;
    tick;
    check("t9_rel_awready", 64'(awready), 64'd1);
    do_read(4'd3, 32'h200, 8'd7, 3'd2, 2'b01);
    for (int i = 0; i < 8; i++)
      check("t9_word", 64'(rbuf[i]), (i < 4) ? 64'hB0 + 64'(i) : 64'hA0 + 64'(i));
    wbuf[0] = 32'h55AA55AA;
    do_write(4'd4, 32'h80, 8'd0, 3'd2, 2'b01);
    check("t9_new_bresp", 64'(b_resp_got), 64'd0);
    check("t9_new_bid", 64'(b_id_got), 64'd4);
    do_read(4'd4, 32'h80, 8'd0, 3'd2, 2'b01);
    check("t9_new_rdata", 64'(rbuf[0]), 64'h55AA55AA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
